// File: rtl/hexport_scan_driver_if.sv
// hexport_scan_driver_if
//   Signal bundle between the PIO hex output port side and the seven-segment
//   scan driver.
//   data_in    : 32-bit display word, byte k drives digit k
//   decode_en  : 0 = raw segment bytes, 1 = hex-font decode of low nibble
//   blink_en   : live whole-display blink enable
//   seg_n      : active-low segments {dp,g,f,e,d,c,b,a}
//   dig_n      : active-low digit enables, at most one low
//   frame_tick : one-cycle pulse in the cycle after each frame start
//   master modport: word source / observer; slave modport: the scan driver.
interface hexport_scan_driver_if;
    logic [31:0] data_in;
    logic        decode_en;
    logic        blink_en;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;
    logic        frame_tick;

    modport master (
        output data_in, decode_en, blink_en,
        input  seg_n, dig_n, frame_tick
    );

    modport slave (
        input  data_in, decode_en, blink_en,
        output seg_n, dig_n, frame_tick
    );
endinterface

// File: rtl/hexport_scan_driver.sv
// hexport_scan_driver
//   Time-multiplexed 4-digit seven-segment driver. The 32-bit display word and
//   the decode mode are shadowed only at frame start, so a frame never shows a
//   mix of old and new data. Each digit slot begins with DEAD blanking cycles
//   to avoid ghosting; an optional blink blanks whole frames.
//   Ports:
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : slave side of hexport_scan_driver_if (data_in, decode_en,
//               blink_en in; seg_n, dig_n, frame_tick out, all registered)
//   Parameters:
//     CLK_DIV      : clk cycles per digit slot (>= DEAD+2)
//     DEAD         : blanking cycles at the start of each slot (>= 1)
//     BLINK_FRAMES : frames per blink half-period (>= 1)
module hexport_scan_driver #(
    parameter int CLK_DIV      = 50000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hexport_scan_driver_if.slave  bus
);
    localparam int NUM_DIGITS = 4;
    localparam int CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_C  = CNT_W'(DEAD);
    localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(BLINK_FRAMES - 1);

    // 7-bit active-low hex font, bit order g..a.
    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        f = 7'h7F;
        case (n)
            4'h0: f = 7'h40;  4'h1: f = 7'h79;  4'h2: f = 7'h24;  4'h3: f = 7'h30;
            4'h4: f = 7'h19;  4'h5: f = 7'h12;  4'h6: f = 7'h02;  4'h7: f = 7'h78;
            4'h8: f = 7'h00;  4'h9: f = 7'h10;  4'hA: f = 7'h08;  4'hB: f = 7'h03;
            4'hC: f = 7'h46;  4'hD: f = 7'h21;  4'hE: f = 7'h06;  4'hF: f = 7'h0E;
            default: f = 7'h7F;
        endcase
        return f;
    endfunction

    logic [CNT_W-1:0]                 cnt;
    logic [1:0]                       idx;
    logic [NUM_DIGITS-1:0][7:0]       shadow;
    logic                             shadow_dec;
    logic [FC_W-1:0]                  fc;
    logic                             phase;
    logic                             started;   // an FS has already happened since reset
    logic [7:0]                       seg_q;
    logic [3:0]                       dig_q;
    logic                             tick_q;

    logic                             cnt_wrap;
    logic                             fs;
    logic                             blank;
    logic [NUM_DIGITS-1:0][7:0]       pat;

    assign cnt_wrap = (cnt == CNT_MAX);
    assign fs       = (cnt == '0) && (idx == 2'd0);
    // DEAD >= 1 guarantees the FS cycle itself is blanked, so the shadow
    // reload on that edge is never visible as a torn digit.
    assign blank    = (bus.blink_en & phase) | (cnt < DEAD_C);

    // Per-digit segment pattern from the shadowed byte.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_pat
        assign pat[d] = shadow_dec ? {~shadow[d][7], font(shadow[d][3:0])} : shadow[d];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow     <= '1;
            shadow_dec <= 1'b0;
            fc         <= '0;
            phase      <= 1'b0;
            started    <= 1'b0;
            seg_q      <= 8'hFF;
            dig_q      <= 4'hF;
            tick_q     <= 1'b0;
        end else begin
            cnt    <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap)
                idx <= idx + 2'd1;
            tick_q <= fs;

            if (fs) begin
                shadow     <= bus.data_in;
                shadow_dec <= bus.decode_en;
                started    <= 1'b1;
                // The first FS after reset opens frame 0 and does not count.
                if (started) begin
                    if (fc == FC_MAX) begin
                        fc    <= '0;
                        phase <= ~phase;
                    end else begin
                        fc <= fc + 1'b1;
                    end
                end
            end

            if (blank) begin
                seg_q <= 8'hFF;
                dig_q <= 4'hF;
            end else begin
                seg_q <= pat[idx];
                dig_q <= ~(4'b0001 << idx);
            end
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dig_n      = dig_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_hexport_scan_driver.sv
module tb_hexport_scan_driver;
    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;
    localparam int BF      = 2;
    localparam int FRAME   = 4 * CLK_DIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hexport_scan_driver_if bus();

    hexport_scan_driver #(.CLK_DIV(CLK_DIV), .DEAD(DEAD), .BLINK_FRAMES(BF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       ft;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    // Reference model: cycle t since reset release determines frame, digit
    // slot and slot position by plain division; the word is whatever data_in
    // held on the edge that opened the current frame.
    int unsigned t = 0;
    logic [31:0] fw;
    logic        fdec;
    always @(posedge clk) begin
        if (!reset_n) begin
            t = 0;
        end else begin
            int unsigned c, slot, f;
            logic [7:0] b;
            logic blank;
            exp_t e;
            c    = t % CLK_DIV;
            slot = (t / CLK_DIV) % 4;
            f    = t / FRAME;
            if (t % FRAME == 0) begin
                fw   = bus.data_in;
                fdec = bus.decode_en;
            end
            b     = fw[8*slot +: 8];
            blank = (bus.blink_en && ((f / BF) % 2 == 1)) || (c < DEAD);
            e.ft  = (t % FRAME == 0);
            if (blank) begin
                e.seg = 8'hFF;
                e.dig = 4'hF;
            end else begin
                e.seg = fdec ? {~b[7], FONT[b[3:0]]} : b;
                e.dig = 4'hF & ~(4'b0001 << slot);
            end
            q.push_back(e);
            t++;
        end
    end

    // Monitor: compares every output cycle against the scoreboard.
    int mon_cyc = 0;
    int last_tick = -1;
    always @(negedge clk) begin
        mon_cyc++;
        if (!reset_n || q.size() == 0) begin
            chk("reset_seg", {24'h0, bus.seg_n}, 32'hFF);
            chk("reset_dig", {28'h0, bus.dig_n}, 32'hF);
            chk("reset_tick", {31'h0, bus.frame_tick}, 32'h0);
            last_tick = -1;
        end else begin
            exp_t e;
            e = q.pop_front();
            chk("seg_n", {24'h0, bus.seg_n}, {24'h0, e.seg});
            chk("dig_n", {28'h0, bus.dig_n}, {28'h0, e.dig});
            chk("frame_tick", {31'h0, bus.frame_tick}, {31'h0, e.ft});
            if (bus.frame_tick) begin
                if (last_tick >= 0)
                    chk("tick_gap", mon_cyc - last_tick, FRAME);
                last_tick = mon_cyc;
            end
        end
        chk("dig_onehot", {31'h0, ($countones(~bus.dig_n) <= 1)}, 32'h1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_t(input int unsigned target);
        int k;
        for (k = 0; k < 20000 && t < target; k++) cyc(1);
        if (t < target) chk("wait_t_timeout", t, target);
    endtask

    // Asynchronous reset: outputs must fall to reset values with no clock.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("async_seg", {24'h0, bus.seg_n}, 32'hFF);
        chk("async_dig", {28'h0, bus.dig_n}, 32'hF);
        chk("async_tick", {31'h0, bus.frame_tick}, 32'h0);
        q.delete();
        cyc(3);
        reset_n = 1'b1;
    endtask

    initial begin
        int unsigned base;
        bus.data_in   = 32'h1234_5678;
        bus.decode_en = 1'b0;
        bus.blink_en  = 1'b0;

        // Raw mode after reset.
        cyc(2);
        do_reset();
        cyc(2 * FRAME + 3);

        // Decode mode.
        bus.data_in   = 32'h0F00_00A3;
        bus.decode_en = 1'b1;
        cyc(3 * FRAME);

        // Tear-free capture: change the word in the digit-1 slot.
        bus.data_in   = 32'h1111_1111;
        bus.decode_en = 1'b0;
        cyc(FRAME);
        base = (t / FRAME + 1) * FRAME;
        wait_t(base + CLK_DIV + 3);
        bus.data_in = 32'h2222_2222;
        cyc(2 * FRAME);
        // Mode toggle mid-frame (digit 2 slot).
        base = (t / FRAME + 1) * FRAME;
        wait_t(base + 2 * CLK_DIV + 4);
        bus.decode_en = 1'b1;
        cyc(2 * FRAME);

        // Blink from reset, six frames.
        bus.blink_en = 1'b1;
        bus.data_in  = 32'hA5C3_0F81;
        do_reset();
        cyc(6 * FRAME + 2);
        // Blink released during frame 3.
        do_reset();
        wait_t(3 * FRAME + 10);
        bus.blink_en = 1'b0;
        cyc(3 * FRAME);

        // Reset during the digit-2 lit window, new word during reset.
        base = (t / FRAME + 1) * FRAME;
        wait_t(base + 2 * CLK_DIV + DEAD + 2);
        bus.data_in = 32'h7E3C_9A15;
        do_reset();
        cyc(2 * FRAME);

        // Continuous random run over 1000 frames.
        for (int i = 0; i < 1000 * FRAME; i++) begin
            if ($urandom_range(15) == 0) bus.data_in = $urandom;
            if ($urandom_range(31) == 0) bus.decode_en = ~bus.decode_en;
            if ($urandom_range(63) == 0) bus.blink_en = ~bus.blink_en;
            cyc(1);
        end
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
